// File: rtl/pong_game_sched_pkg.sv
// Shared types and defaults for the TinyPong frame scheduler.
// Provides the game_state encoding, default constants, widths and a helper.
package pong_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SERVE     = 3'd1,
      PLAY      = 3'd2,
      UPD_BALL  = 3'd3,
      WAIT_BALL = 3'd4,
      OVER      = 3'd5
   } game_state_e;

   localparam int SERVE_FRAMES_DEF = 60;
   localparam int LIVES_DEF        = 3;
   localparam int MAX_SCORE_DEF    = 9;

   localparam int SCORE_W = 4;
   localparam int LIVES_W = 2;
   localparam int SPEED_W = 2;

   function automatic logic [SCORE_W-1:0] sat_inc(
      input logic [SCORE_W-1:0] v,
      input logic [SCORE_W-1:0] lim
   );
      return (v >= lim) ? lim : v + 1'b1;
   endfunction

endpackage

// File: rtl/pong_game_sched_if.sv
// Scheduler <-> datapath bundle: frame pulse, update strobes, ball results.
// master = scheduler side, slave = paddle/ball datapath side.
interface pong_game_sched_if;
   import pong_pkg::*;

   logic               frame_start;
   logic               paddle_en;
   logic               ball_en;
   logic               ball_reset;
   logic [SPEED_W-1:0] ball_speed;
   logic               ball_done;
   logic               paddle_hit;
   logic               ball_miss;

   modport master (
      input  frame_start,
      input  ball_done,
      input  paddle_hit,
      input  ball_miss,
      output paddle_en,
      output ball_en,
      output ball_reset,
      output ball_speed
   );

   modport slave (
      output frame_start,
      output ball_done,
      output paddle_hit,
      output ball_miss,
      input  paddle_en,
      input  ball_en,
      input  ball_reset,
      input  ball_speed
   );

endinterface

// File: rtl/pong_game_sched_speed_ctrl.sv
// Ball speed level: counts paddle hits, bumps speed every SPEEDUP_HITS.
// Ports: clk, rst_n, clear (new serve/game), hit (one bounce), ball_speed.
module pong_speed_ctrl
   import pong_pkg::*;
#(
   parameter int SPEEDUP_HITS = 4,
   parameter int MAX_SPEED    = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               hit,
   output logic [SPEED_W-1:0] ball_speed
);

   localparam int HW = $clog2(SPEEDUP_HITS + 1);
   localparam logic [HW-1:0] HIT_LAST = HW'(SPEEDUP_HITS - 1);
   localparam logic [SPEED_W-1:0] SPD_MAX = SPEED_W'(MAX_SPEED);

   logic [HW-1:0] hit_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt    <= '0;
         ball_speed <= '0;
      end else if (clear) begin
         hit_cnt    <= '0;
         ball_speed <= '0;
      end else if (hit) begin
         if (hit_cnt == HIT_LAST) begin
            hit_cnt <= '0;
            if (ball_speed != SPD_MAX)
               ball_speed <= ball_speed + 1'b1;
         end else begin
            hit_cnt <= hit_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pong_game_sched.sv
// Per-frame game scheduler: paddle step, ball step, wait for ball result.
// Ports: clk, rst_n, btn_start, bus (datapath bundle), score, lives, game_state, timeout_err.
module pong_game_sched
   import pong_pkg::*;
#(
   parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
   parameter int LIVES        = LIVES_DEF,
   parameter int MAX_SCORE    = MAX_SCORE_DEF,
   parameter int SPEEDUP_HITS = 4,
   parameter int MAX_SPEED    = 3,
   parameter int DONE_TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               btn_start,
   pong_game_sched_if.master  bus,
   output logic [SCORE_W-1:0] score,
   output logic [LIVES_W-1:0] lives,
   output logic [2:0]         game_state,
   output logic               timeout_err
);

   localparam int SW = $clog2(SERVE_FRAMES + 1);
   localparam int TW = $clog2(DONE_TIMEOUT + 1);
   localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_FRAMES - 1);
   localparam logic [TW-1:0] TO_LAST = TW'(DONE_TIMEOUT - 1);
   localparam logic [LIVES_W-1:0] LV_INIT = LIVES_W'(LIVES);
   localparam logic [SCORE_W-1:0] SC_MAX = SCORE_W'(MAX_SCORE);

   game_state_e        state, state_d;
   logic [SW-1:0]      serve_cnt, serve_d;
   logic [TW-1:0]      to_cnt, to_d;
   logic [SCORE_W-1:0] score_d;
   logic [LIVES_W-1:0] lives_d;
   logic               terr_d;
   logic               pad_q, pad_d;
   logic               ball_q, ball_d;
   logic               brst_q, brst_d;
   logic               btn_q;
   logic               btn_rise;
   logic               spd_clr;
   logic               spd_hit;
   logic [SPEED_W-1:0] speed;

   assign btn_rise = btn_start & ~btn_q;

   always_comb begin
      state_d = state;
      serve_d = serve_cnt;
      to_d    = to_cnt;
      score_d = score;
      lives_d = lives;
      terr_d  = timeout_err;
      pad_d   = 1'b0;
      ball_d  = 1'b0;
      brst_d  = 1'b0;
      spd_clr = 1'b0;
      spd_hit = 1'b0;
      unique case (state)
         IDLE, OVER: begin
            if (btn_rise) begin
               score_d = '0;
               lives_d = LV_INIT;
               spd_clr = 1'b1;
               serve_d = '0;
               brst_d  = 1'b1;
               state_d = SERVE;
            end
         end
         SERVE: begin
            if (bus.frame_start) begin
               pad_d = 1'b1;
               if (serve_cnt == SERVE_LAST) begin
                  serve_d = '0;
                  state_d = PLAY;
               end else begin
                  serve_d = serve_cnt + 1'b1;
               end
            end
         end
         PLAY: begin
            if (bus.frame_start) begin
               pad_d   = 1'b1;
               state_d = UPD_BALL;
            end
         end
         UPD_BALL: begin
            ball_d  = 1'b1;
            to_d    = '0;
            state_d = WAIT_BALL;
         end
         WAIT_BALL: begin
            if (bus.ball_done) begin
               // a miss outranks a same-update bounce
               if (bus.ball_miss) begin
                  lives_d = lives - 1'b1;
                  if (lives == LIVES_W'(1)) begin
                     state_d = OVER;
                  end else begin
                     brst_d  = 1'b1;
                     spd_clr = 1'b1;
                     serve_d = '0;
                     state_d = SERVE;
                  end
               end else begin
                  if (bus.paddle_hit) begin
                     score_d = sat_inc(score, SC_MAX);
                     spd_hit = 1'b1;
                  end
                  state_d = PLAY;
               end
            end else if (to_cnt == TO_LAST) begin
               // datapath hung: log it and keep the game running
               terr_d  = 1'b1;
               state_d = PLAY;
            end else begin
               to_d = to_cnt + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         serve_cnt   <= '0;
         to_cnt      <= '0;
         score       <= '0;
         lives       <= LV_INIT;
         timeout_err <= 1'b0;
         pad_q       <= 1'b0;
         ball_q      <= 1'b0;
         brst_q      <= 1'b0;
         btn_q       <= 1'b0;
      end else begin
         state       <= state_d;
         serve_cnt   <= serve_d;
         to_cnt      <= to_d;
         score       <= score_d;
         lives       <= lives_d;
         timeout_err <= terr_d;
         pad_q       <= pad_d;
         ball_q      <= ball_d;
         brst_q      <= brst_d;
         btn_q       <= btn_start;
      end
   end

   pong_speed_ctrl #(
      .SPEEDUP_HITS (SPEEDUP_HITS),
      .MAX_SPEED    (MAX_SPEED)
   ) u_speed (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (spd_clr),
      .hit        (spd_hit),
      .ball_speed (speed)
   );

   assign bus.paddle_en  = pad_q;
   assign bus.ball_en    = ball_q;
   assign bus.ball_reset = brst_q;
   assign bus.ball_speed = speed;
   assign game_state     = state;

endmodule

// File: tb/tb_pong_game_sched.sv
// Directed bench for pong_game_sched with a game-level reference model.
// Model schedules expected strobes/values per cycle; one process compares.
module tb_pong_game_sched;

   localparam int S_IDLE  = 0;
   localparam int S_SERVE = 1;
   localparam int S_PLAY  = 2;
   localparam int S_UPD   = 3;
   localparam int S_WAIT  = 4;
   localparam int S_OVER  = 5;

   localparam int P_IDLE  = 0;
   localparam int P_SERVE = 1;
   localparam int P_PLAY  = 2;
   localparam int P_BUSY  = 3;
   localparam int P_OVER  = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_start;
   logic [3:0] score;
   logic [1:0] lives;
   logic [2:0] game_state;
   logic       timeout_err;

   pong_game_sched_if bus();

   pong_game_sched dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_start   (btn_start),
      .bus         (bus),
      .score       (score),
      .lives       (lives),
      .game_state  (game_state),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   bit exp_pad[int];
   bit exp_ball[int];
   bit exp_rst[int];
   int st_at[int];
   int sc_at[int];
   int lv_at[int];
   int sp_at[int];
   int te_at[int];

   int m_state = S_IDLE;
   int m_score = 0;
   int m_lives = 3;
   int m_speed = 0;
   int m_terr  = 0;

   int phase = P_IDLE;
   int serve_left = 0;
   int hits = 0;
   int g_score = 0;
   int g_lives = 3;
   int ball_cyc = 0;

   function automatic int imin(int a, int b);
      return (a < b) ? a : b;
   endfunction

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (st_at.exists(cyc)) m_state = st_at[cyc];
         if (sc_at.exists(cyc)) m_score = sc_at[cyc];
         if (lv_at.exists(cyc)) m_lives = lv_at[cyc];
         if (sp_at.exists(cyc)) m_speed = sp_at[cyc];
         if (te_at.exists(cyc)) m_terr  = te_at[cyc];
         check("paddle_en", 32'(bus.paddle_en), 32'(exp_pad.exists(cyc)));
         check("ball_en", 32'(bus.ball_en), 32'(exp_ball.exists(cyc)));
         check("ball_reset", 32'(bus.ball_reset), 32'(exp_rst.exists(cyc)));
         check("game_state", 32'(game_state), m_state);
         check("score", 32'(score), m_score);
         check("lives", 32'(lives), m_lives);
         check("ball_speed", 32'(bus.ball_speed), m_speed);
         check("timeout_err", 32'(timeout_err), m_terr);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press_start();
      btn_start = 1'b1;
      if (phase == P_IDLE || phase == P_OVER) begin
         exp_rst[cyc+1] = 1'b1;
         st_at[cyc+1] = S_SERVE;
         sc_at[cyc+1] = 0;
         lv_at[cyc+1] = 3;
         sp_at[cyc+1] = 0;
         phase = P_SERVE;
         serve_left = 60;
         hits = 0;
         g_score = 0;
         g_lives = 3;
      end
      repeat (3) tick();
      btn_start = 1'b0;
      tick();
   endtask

   task automatic frame();
      bus.frame_start = 1'b1;
      case (phase)
         P_SERVE: begin
            exp_pad[cyc+1] = 1'b1;
            serve_left--;
            if (serve_left == 0) begin
               st_at[cyc+1] = S_PLAY;
               phase = P_PLAY;
            end
         end
         P_PLAY: begin
            exp_pad[cyc+1] = 1'b1;
            exp_ball[cyc+2] = 1'b1;
            st_at[cyc+1] = S_UPD;
            st_at[cyc+2] = S_WAIT;
            ball_cyc = cyc + 2;
            phase = P_BUSY;
         end
         default: ;
      endcase
      tick();
      bus.frame_start = 1'b0;
      tick();
      tick();
   endtask

   task automatic serve_all();
      repeat (60) frame();
   endtask

   task automatic result(bit hit, bit miss);
      bus.ball_done = 1'b1;
      bus.paddle_hit = hit;
      bus.ball_miss = miss;
      if (phase == P_BUSY) begin
         if (miss) begin
            g_lives--;
            lv_at[cyc+1] = g_lives;
            if (g_lives == 0) begin
               st_at[cyc+1] = S_OVER;
               phase = P_OVER;
            end else begin
               st_at[cyc+1] = S_SERVE;
               exp_rst[cyc+1] = 1'b1;
               sp_at[cyc+1] = 0;
               hits = 0;
               serve_left = 60;
               phase = P_SERVE;
            end
         end else begin
            if (hit) begin
               hits++;
               g_score = imin(g_score + 1, 9);
               sc_at[cyc+1] = g_score;
               sp_at[cyc+1] = imin(hits / 4, 3);
            end
            st_at[cyc+1] = S_PLAY;
            phase = P_PLAY;
         end
      end
      tick();
      bus.ball_done = 1'b0;
      bus.paddle_hit = 1'b0;
      bus.ball_miss = 1'b0;
      tick();
   endtask

   task automatic rally_hit();
      frame();
      result(1'b1, 1'b0);
   endtask

   task automatic await_timeout();
      st_at[ball_cyc+255] = S_PLAY;
      te_at[ball_cyc+255] = 1;
      while (cyc < ball_cyc + 100) tick();
      frame();
      while (cyc < ball_cyc + 257) tick();
      phase = P_PLAY;
   endtask

   task automatic check_reset_vals(string tag);
      check({tag, "_state"}, 32'(game_state), 0);
      check({tag, "_score"}, 32'(score), 0);
      check({tag, "_lives"}, 32'(lives), 3);
      check({tag, "_speed"}, 32'(bus.ball_speed), 0);
      check({tag, "_terr"}, 32'(timeout_err), 0);
      check({tag, "_pad"}, 32'(bus.paddle_en), 0);
      check({tag, "_ball"}, 32'(bus.ball_en), 0);
      check({tag, "_brst"}, 32'(bus.ball_reset), 0);
   endtask

   initial begin
      btn_start = 1'b0;
      bus.frame_start = 1'b0;
      bus.ball_done = 1'b0;
      bus.paddle_hit = 1'b0;
      bus.ball_miss = 1'b0;
      repeat (3) tick();
      check_reset_vals("rst");
      rst_n = 1'b1;
      chk_en = 1'b1;
      tick();

      frame();
      press_start();
      check("start_state", 32'(game_state), 1);
      check("start_lives", 32'(lives), 3);
      serve_all();
      check("serve_done", 32'(game_state), 2);

      press_start();
      rally_hit();
      check("hit1_score", 32'(score), 1);
      check("hit1_state", 32'(game_state), 2);
      for (int i = 2; i <= 16; i++) begin
         rally_hit();
         if (i == 4) check("spd_4hits", 32'(bus.ball_speed), 1);
         if (i == 12) check("spd_12hits", 32'(bus.ball_speed), 3);
      end
      check("spd_16hits", 32'(bus.ball_speed), 3);
      check("score_sat", 32'(score), 9);

      frame();
      result(1'b1, 1'b1);
      check("miss_lives", 32'(lives), 2);
      check("miss_score", 32'(score), 9);
      check("miss_speed", 32'(bus.ball_speed), 0);
      check("miss_state", 32'(game_state), 1);

      serve_all();
      frame();
      await_timeout();
      check("to_err", 32'(timeout_err), 1);
      check("to_state", 32'(game_state), 2);

      frame();
      result(1'b0, 1'b1);
      serve_all();
      rally_hit();
      frame();
      result(1'b0, 1'b1);
      check("over_state", 32'(game_state), 5);
      check("over_lives", 32'(lives), 0);
      frame();

      press_start();
      check("new_score", 32'(score), 0);
      check("new_lives", 32'(lives), 3);
      serve_all();
      frame();
      repeat (5) tick();

      chk_en = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_vals("async");
      exp_pad.delete();
      exp_ball.delete();
      exp_rst.delete();
      st_at.delete();
      sc_at.delete();
      lv_at.delete();
      sp_at.delete();
      te_at.delete();
      tick();
      tick();
      rst_n = 1'b1;
      st_at[cyc] = S_IDLE;
      sc_at[cyc] = 0;
      lv_at[cyc] = 3;
      sp_at[cyc] = 0;
      te_at[cyc] = 0;
      phase = P_IDLE;
      chk_en = 1'b1;
      repeat (4) tick();
      frame();

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/pong_game_sched.md
Name: pong_game_sched

Overview:
- Per-frame game scheduler for the TinyPong VGA design; sits between the VGA timing generator and the paddle/ball update datapaths.
- On each frame_start pulse (start of vertical blanking) it sequences one paddle update, then one ball update, and waits for the ball datapath to report completion.
- Owns game state, serve delay, score, lives and ball speed level.

Parameters:
- SERVE_FRAMES, 60, frames the ball is held at serve position before play resumes.
- LIVES, 3, misses allowed before game over.
- MAX_SCORE, 9, score saturation value.
- SPEEDUP_HITS, 4, paddle hits per speed increment.
- MAX_SPEED, 3, maximum ball_speed value.
- DONE_TIMEOUT, 255, cycles to wait for ball_done before forcing completion.

Ports:
- clk  in  1  25 MHz pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blanking.
- btn_start  in  1  synchronized start button level (the button on ui_in[2]).
- ball_done  in  1  one-cycle pulse; ball datapath finished its update.
- paddle_hit  in  1  qualified with ball_done: ball bounced off paddle this update.
- ball_miss  in  1  qualified with ball_done: ball passed the paddle this update.
- paddle_en  out  1  one-cycle strobe: paddle datapath applies button motion.
- ball_en  out  1  one-cycle strobe: ball datapath performs one step.
- ball_reset  out  1  one-cycle strobe: ball returns to serve position.
- ball_speed  out  2  pixels per step minus 1 (0..MAX_SPEED).
- score  out  4  current score.
- lives  out  2  remaining lives.
- game_state  out  3  state encoding, for the renderer overlay.
- timeout_err  out  1  sticky; set if ball_done ever timed out.

Behaviour:
- Reset (rst_n low, async): state IDLE; all strobes 0; ball_speed 0; score 0; lives LIVES; timeout_err 0; counters 0.
- btn_start is rising-edge detected internally with one register; edge pulse is btn_rise.
- IDLE: outputs quiescent. On btn_rise: load score 0, lives LIVES, ball_speed 0, hit counter 0; pulse ball_reset next cycle; go to SERVE.
- SERVE: serve counter starts at 0. Each frame_start pulses paddle_en (the paddle may move during serve) and increments the counter. When the counter reaches SERVE_FRAMES, go to PLAY; no ball_en is issued in that frame.
- PLAY: waits. On frame_start: paddle_en=1 for the following cycle and go to UPD_BALL.
- UPD_BALL: ball_en=1 for exactly one cycle, the cycle after paddle_en. Clear the timeout counter and go to WAIT_BALL.
- Latency: frame_start at cycle N gives paddle_en at N+1 and ball_en at N+2.
- WAIT_BALL: on ball_done, evaluate the qualifiers:
  - ball_miss has priority over a simultaneous paddle_hit; the hit is ignored.
  - Miss: lives-1. If the new lives value is 0, go to OVER. Otherwise pulse ball_reset, reset ball_speed to 0 and the hit counter to 0, and go to SERVE.
  - Hit: score+1, saturating at MAX_SCORE; hit counter+1. When the hit counter reaches SPEEDUP_HITS, clear it and increment ball_speed, saturating at MAX_SPEED. Return to PLAY.
  - Neither: return to PLAY.
  - If ball_done has not arrived after DONE_TIMEOUT cycles: set timeout_err, treat as a done with no events, return to PLAY.
- frame_start arriving in UPD_BALL or WAIT_BALL is dropped; the frame is skipped, with no queuing.
- OVER: score and lives are frozen for display. On btn_rise, take the same path as from IDLE (new game).
- btn_rise in SERVE, PLAY or WAIT_BALL is ignored.
- Strobes are never asserted simultaneously except where stated; at most one ball_en per frame.
- Reset asserted mid-operation clears everything immediately, including timeout_err.

Decomposition:
- Package pong_pkg: game_state enum (IDLE=0, SERVE=1, PLAY=2, UPD_BALL=3, WAIT_BALL=4, OVER=5), default constants for SERVE_FRAMES, LIVES and MAX_SCORE, and the width SCORE_W=4.
- One natural sub-module: pong_speed_ctrl, containing the hit counter and ball_speed saturation logic, with clear and hit inputs. Everything else stays in the top-level FSM.

Test Plan:
- Reset then btn_start rise: ball_reset pulses once; game_state=SERVE; lives=3, score=0; after 60 frame_start pulses game_state=PLAY with no ball_en seen.
- In PLAY, frame_start at cycle N: paddle_en at N+1, ball_en at N+2; ball_done with paddle_hit → score=1 and state back to PLAY.
- 4 hits give ball_speed=1; 12 hits give ball_speed=3; 16 hits keep ball_speed=3. Score saturates at 9.
- ball_done with ball_miss and paddle_hit both high: lives 3→2, score unchanged, ball_reset pulsed, ball_speed=0, state SERVE. Third miss gives lives=0 and state OVER; a later btn_rise restarts with score=0, lives=3.
- Withhold ball_done for 255 cycles after ball_en: timeout_err=1, state PLAY. A frame_start pulsed while in WAIT_BALL produces no extra paddle_en or ball_en.
- Assert rst_n low during WAIT_BALL: all outputs return to reset values asynchronously, before the next clock edge.
